// File: rtl/switch_input_ctrl_pkg.sv
// Shared constants for the switch input port: register addresses, status bit
// positions and the confirm-button FSM encoding.
package switch_input_ctrl_pkg;
    localparam logic [1:0] IO_DATA   = 2'b00;
    localparam logic [1:0] IO_STATUS = 2'b10;

    localparam int VALID_BIT = 0;
    localparam int OVR_BIT   = 1;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_e;
endpackage

// File: rtl/debounce_sync.sv
// Two-flop synchronizer followed by a hold-time filter: the output only moves
// once the synchronized input has disagreed with it for DEBOUNCE_CYCLES cycles.
module debounce_sync
    import switch_input_ctrl_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int CNT_W           = 17
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] stable_o
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] meta_q, sync_q, stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // A return to the accepted value restarts the count; a new differing
    // value mid-count does not.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync_q != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                stable_d = sync_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta_q   <= '0;
            sync_q   <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
        end else begin
            meta_q   <= din_i;
            sync_q   <= meta_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;
endmodule

// File: rtl/switch_input_ctrl.sv
// CPU input port: debounced switches are latched on each confirmed button
// press and exposed as a data register plus a clear-on-read status register.
module switch_input_ctrl
    import switch_input_ctrl_pkg::*;
#(
    parameter int SW_W            = 4,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int CNT_W           = 17
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [SW_W-1:0] sw_in,
    input  logic            btn_in,
    input  logic            ior,
    input  logic            switchctrl,
    input  logic [1:0]      io_addr,
    output logic [15:0]     ioread_data,
    output logic            data_valid
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SW_W-1:0]  sw_stable;
    logic             btn_meta_q, btn_sync_q;
    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] bcnt_q, bcnt_d;
    logic             cap;
    logic [SW_W-1:0]  data_q, data_d;
    logic             valid_q, valid_d, ovr_q, ovr_d;
    logic             rd_sel, rd_data;
    logic [15:0]      status;

    debounce_sync #(
        .WIDTH          (SW_W),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_sw_db (
        .clock   (clock),
        .reset   (reset),
        .din_i   (sw_in),
        .stable_o(sw_stable)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            btn_meta_q <= 1'b0;
            btn_sync_q <= 1'b0;
        end else begin
            btn_meta_q <= btn_in;
            btn_sync_q <= btn_meta_q;
        end
    end

    // Capture fires only on the PRESS_WAIT -> PRESSED transition, so a held
    // button parks in PRESSED and cannot re-capture.
    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        cap     = 1'b0;
        case (state_q)
            IDLE: begin
                if (btn_sync_q) state_d = PRESS_WAIT;
            end
            PRESS_WAIT: begin
                if (!btn_sync_q) begin
                    state_d = IDLE;
                end else if (bcnt_q == CNT_MAX) begin
                    state_d = PRESSED;
                    cap     = 1'b1;
                end else begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (!btn_sync_q) state_d = RELEASE_WAIT;
            end
            RELEASE_WAIT: begin
                if (btn_sync_q) begin
                    state_d = PRESSED;
                end else if (bcnt_q == CNT_MAX) begin
                    state_d = IDLE;
                end else begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) bcnt_d = '0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
        end
    end

    assign rd_sel  = ior && switchctrl;
    assign rd_data = rd_sel && (io_addr == IO_DATA);

    // A capture coinciding with a data read wins: the CPU got the old value,
    // so the new one is pending with no overrun.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (cap) begin
            data_d  = sw_stable;
            valid_d = 1'b1;
            ovr_d   = valid_q && !rd_data;
        end else if (rd_data) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        status            = '0;
        status[VALID_BIT] = valid_q;
        status[OVR_BIT]   = ovr_q;
        ioread_data       = '0;
        if (rd_sel) begin
            case (io_addr)
                IO_DATA:   ioread_data = 16'(data_q);
                IO_STATUS: ioread_data = status;
                default:   ioread_data = '0;
            endcase
        end
    end

    assign data_valid = valid_q;
endmodule

// File: tb/tb_switch_input_ctrl.sv
// Scoreboard bench for switch_input_ctrl with an 8-cycle debounce window.
module tb_switch_input_ctrl;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  sw_in = 4'h0;
    logic        btn_in = 1'b0;
    logic        ior = 1'b0;
    logic        switchctrl = 1'b0;
    logic [1:0]  io_addr = 2'b00;
    logic [15:0] ioread_data;
    logic        data_valid;

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0]  m_data  = 4'h0;
    logic        m_valid = 1'b0;
    logic        m_ovr   = 1'b0;
    logic [15:0] sbq[$];

    switch_input_ctrl #(
        .SW_W           (4),
        .DEBOUNCE_CYCLES(8),
        .CNT_W          (4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .sw_in      (sw_in),
        .btn_in     (btn_in),
        .ior        (ior),
        .switchctrl (switchctrl),
        .io_addr    (io_addr),
        .ioread_data(ioread_data),
        .data_valid (data_valid)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic model_cap(input logic [3:0] v);
        if (m_valid) m_ovr = 1'b1;
        m_valid = 1'b1;
        m_data  = v;
    endtask

    // Expected read value is queued from the model, then popped against the DUT.
    task automatic rd(input logic [1:0] a, input logic cs, input string tag);
        logic [15:0] e;
        if (!cs)              e = '0;
        else if (a == 2'b00)  e = {12'b0, m_data};
        else if (a == 2'b10)  e = {14'b0, m_ovr, m_valid};
        else                  e = '0;
        sbq.push_back(e);
        ior = 1'b1; switchctrl = cs; io_addr = a;
        #1;
        chk(tag, ioread_data, sbq.pop_front());
        tick();
        ior = 1'b0; switchctrl = 1'b0; io_addr = 2'b00;
        if (cs && a == 2'b00 && reset) begin
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end
    endtask

    // Counts edges from now until data_valid rises; 31 means it never did.
    task automatic wait_valid(output int k);
        k = 31;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (data_valid) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic press(input logic [3:0] v, input bit glitch);
        sw_in = v;
        tick(12);
        btn_in = 1'b1;
        if (glitch) begin
            sw_in = ~v;
            tick(5);
            sw_in = v;
            tick(15);
        end else begin
            tick(20);
        end
        btn_in = 1'b0;
        tick(14);
        model_cap(v);
    endtask

    initial begin
        int k;

        // Reset with button and switches already active
        reset = 1'b0; sw_in = 4'hF; btn_in = 1'b1;
        tick(3);
        chk("rst_valid", {31'b0, data_valid}, 0);
        for (int a = 0; a < 4; a++) rd(2'(a), 1'b1, "rst_rd");
        reset = 1'b1;
        wait_valid(k);
        chk("rst_lat", k, 11);
        model_cap(4'hF);
        btn_in = 1'b0;
        tick(14);
        rd(2'b01, 1'b1, "addr01");
        rd(2'b11, 1'b1, "addr11");
        rd(2'b10, 1'b0, "no_cs");
        rd(2'b00, 1'b1, "rst_data");
        rd(2'b10, 1'b1, "rst_stat_clr");

        // Basic capture and latency
        sw_in = 4'hA;
        tick(12);
        btn_in = 1'b1;
        wait_valid(k);
        chk("cap_lat", k, 11);
        model_cap(4'hA);
        tick(20 - k);
        btn_in = 1'b0;
        tick(14);
        rd(2'b10, 1'b1, "cap_stat");
        rd(2'b00, 1'b1, "cap_data");
        chk("cap_clr", {31'b0, data_valid}, 0);
        rd(2'b10, 1'b1, "cap_stat_clr");

        // Button bounce never captures
        for (int i = 0; i < 10; i++) begin
            btn_in = ~btn_in;
            tick(3);
        end
        btn_in = 1'b0;
        tick(14);
        chk("bounce_valid", {31'b0, data_valid}, 0);
        rd(2'b10, 1'b1, "bounce_stat");

        // Short switch glitch during the button debounce is ignored
        press(4'h5, 1'b1);
        rd(2'b00, 1'b1, "glitch_data");

        // Overrun: two presses without an intervening read
        press(4'h3, 1'b0);
        press(4'h5, 1'b0);
        rd(2'b10, 1'b1, "ovr_stat");
        rd(2'b00, 1'b1, "ovr_data");
        rd(2'b10, 1'b1, "ovr_stat_clr");

        // Data read landing on the capture cycle, with valid already pending
        press(4'h6, 1'b0);
        sw_in = 4'h9;
        tick(12);
        btn_in = 1'b1;
        tick(10);
        sbq.push_back({12'b0, m_data});
        ior = 1'b1; switchctrl = 1'b1; io_addr = 2'b00;
        #1;
        chk("coll_rd", ioread_data, sbq.pop_front());
        tick();
        ior = 1'b0; switchctrl = 1'b0;
        m_data = 4'h9; m_valid = 1'b1; m_ovr = 1'b0;
        chk("coll_valid", {31'b0, data_valid}, 1);
        btn_in = 1'b0;
        tick(14);
        rd(2'b10, 1'b1, "coll_stat");
        rd(2'b00, 1'b1, "coll_data");

        // Reset in the middle of a press debounce
        press(4'hC, 1'b0);
        btn_in = 1'b1;
        tick(6);
        reset = 1'b0;
        #1;
        m_data = 4'h0; m_valid = 1'b0; m_ovr = 1'b0;
        chk("midrst_valid", {31'b0, data_valid}, 0);
        rd(2'b10, 1'b1, "midrst_stat");
        reset = 1'b1;
        wait_valid(k);
        chk("midrst_lat", k, 11);
        model_cap(4'hC);
        btn_in = 1'b0;
        tick(14);
        rd(2'b00, 1'b1, "midrst_data");
        press(4'h7, 1'b0);
        rd(2'b10, 1'b1, "post_stat");
        rd(2'b00, 1'b1, "post_data");
        rd(2'b10, 1'b1, "post_stat_clr");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
